// File: rtl/mult_div_unit_if.sv
// Operand/result bundle between the E-stage datapath and the multiply/divide unit.
// Handshake: a non-zero md_op is the request (valid); the unit accepts it on the
// rising edge only when busy is low. stall_req is the back-pressure (not-ready)
// seen by decode: while it is high, decode must hold md-class instructions, and
// any request presented while busy is high is dropped without side effects.
interface mult_div_unit_if;
  logic [3:0]  md_op;
  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] md_out;
  logic        busy;
  logic        stall_req;

  modport master (
    output md_op, a, b,
    input  md_out, busy, stall_req
  );

  modport slave (
    input  md_op, a, b,
    output md_out, busy, stall_req
  );
endinterface

// File: rtl/mult_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// The result is computed at start into pend_hi/pend_lo and committed to hi/lo
// when the busy counter expires; mfhi/mflo always read the committed registers.
module mult_div_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic            clk,
  input  logic            reset,
  mult_div_unit_if.slave  md_if
);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  // The FSM state is the busy flag itself and is visible on md_if.busy.
  typedef enum logic {S_IDLE = 1'b0, S_BUSY = 1'b1} state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_hi;
  logic [31:0] r_lo;
  logic [31:0] r_pend_hi;
  logic [31:0] r_pend_lo;
  logic [3:0]  r_cnt;
  logic        r_div0;

  logic        w_busy;
  logic        w_is_md;
  logic        w_start;
  logic        w_is_div;
  logic        w_b_zero;
  logic [63:0] w_smul;
  logic [63:0] w_umul;
  logic [31:0] w_dvd;
  logic [31:0] w_dvs;
  logic [31:0] w_uq;
  logic [31:0] w_ur;
  logic [31:0] w_sq;
  logic [31:0] w_sr;
  logic [63:0] w_result;

  assign w_busy   = (r_state == S_BUSY);
  assign w_is_md  = (md_if.md_op >= OP_MULT) && (md_if.md_op <= OP_DIVU);
  assign w_start  = w_is_md && !w_busy;
  assign w_is_div = (md_if.md_op == OP_DIV) || (md_if.md_op == OP_DIVU);
  assign w_b_zero = (md_if.b == 32'd0);

  // Both products are formed at full 64-bit width from extended operands.
  assign w_smul = {{32{md_if.a[31]}}, md_if.a} * {{32{md_if.b[31]}}, md_if.b};
  assign w_umul = {32'd0, md_if.a} * {32'd0, md_if.b};

  // One unsigned divider serves both div and divu; signed div works on magnitudes.
  // A zero divisor is replaced by 1 only to keep the datapath X-free; the result
  // is never committed in that case.
  assign w_dvd = ((md_if.md_op == OP_DIV) && md_if.a[31]) ? -md_if.a : md_if.a;
  assign w_dvs = w_b_zero ? 32'd1 :
                 (((md_if.md_op == OP_DIV) && md_if.b[31]) ? -md_if.b : md_if.b);
  assign w_uq  = w_dvd / w_dvs;
  assign w_ur  = w_dvd % w_dvs;
  // Quotient truncates toward zero; remainder follows the dividend's sign.
  // 0x80000000 / -1 falls out naturally as 0x80000000 rem 0.
  assign w_sq  = (md_if.a[31] ^ md_if.b[31]) ? -w_uq : w_uq;
  assign w_sr  = md_if.a[31] ? -w_ur : w_ur;

  // Select the staged {hi,lo} result for the operation being started.
  always_comb begin
    w_result = 64'd0;
    case (md_if.md_op)
      OP_MULT:  w_result = w_smul;
      OP_MULTU: w_result = w_umul;
      OP_DIV:   w_result = {w_sr, w_sq};
      OP_DIVU:  w_result = {w_ur, w_uq};
      default:  w_result = 64'd0;
    endcase
  end

  // Next-state logic: idle until a start is accepted, busy until the count expires.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_start) w_state_nxt = S_BUSY;
      S_BUSY:  if (r_cnt == 4'd1) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Datapath registers: start capture, countdown and commit, mthi/mtlo writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hi      <= 32'd0;
      r_lo      <= 32'd0;
      r_pend_hi <= 32'd0;
      r_pend_lo <= 32'd0;
      r_cnt     <= 4'd0;
      r_div0    <= 1'b0;
    end else if (w_start) begin
      r_pend_hi <= w_result[63:32];
      r_pend_lo <= w_result[31:0];
      r_cnt     <= w_is_div ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      r_div0    <= w_is_div && w_b_zero;
    end else if (w_busy) begin
      r_cnt <= r_cnt - 4'd1;
      if ((r_cnt == 4'd1) && !r_div0) begin
        r_hi <= r_pend_hi;
        r_lo <= r_pend_lo;
      end
    end else if (md_if.md_op == OP_MTHI) begin
      r_hi <= md_if.a;
    end else if (md_if.md_op == OP_MTLO) begin
      r_lo <= md_if.a;
    end
  end

  // Read port: committed HI/LO only, zero for every other operation.
  always_comb begin
    md_if.md_out = 32'd0;
    case (md_if.md_op)
      OP_MFHI: md_if.md_out = r_hi;
      OP_MFLO: md_if.md_out = r_lo;
      default: md_if.md_out = 32'd0;
    endcase
  end

  assign md_if.busy      = w_busy;
  assign md_if.stall_req = w_busy || w_is_md;

endmodule

// File: tb/tb_mult_div_unit.sv
// Bench for mult_div_unit: vector table, random ops against a 64-bit model,
// and hand-written sequences for reset, ignore-while-busy and back-to-back.
module tb_mult_div_unit;

  logic clk;
  logic reset;

  mult_div_unit_if md_if ();

  mult_div_unit dut (
    .clk   (clk),
    .reset (reset),
    .md_if (md_if)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    int          n;
  } vec_t;

  logic [63:0] exp_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Independent reference built on 64-bit arithmetic.
  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    longint          sa, sb, sq, sr, sp;
    longint unsigned ua, ub;
    logic [63:0]     r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    r  = 64'd0;
    case (op)
      4'd1: begin sp = sa * sb; r = sp; end
      4'd2: r = ua * ub;
      4'd3: begin sq = sa / sb; sr = sa % sb; r = {sr[31:0], sq[31:0]}; end
      4'd4: r = {32'(ua % ub), 32'(ua / ub)};
      default: r = 64'd0;
    endcase
    return r;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [63:0] exp, input bit push);
    md_if.md_op = op;
    md_if.a     = a;
    md_if.b     = b;
    #1;
    chk({name, " stall_req at start"}, 64'(md_if.stall_req), 64'd1);
    chk({name, " idle at start"}, 64'(md_if.busy), 64'd0);
    if (push) exp_q.push_back(exp);
    step();
    md_if.md_op = 4'd0;
  endtask

  task automatic wait_done(input string name, input int n);
    int c = 0;
    while (md_if.busy === 1'b1 && c < 40) begin
      c++;
      step();
    end
    chk({name, " busy cycles"}, 64'(c), 64'(n));
    chk({name, " stall_req after"}, 64'(md_if.stall_req), 64'd0);
  endtask

  task automatic read_hilo(output logic [31:0] hi, output logic [31:0] lo);
    md_if.md_op = 4'd5;
    #1;
    hi = md_if.md_out;
    md_if.md_op = 4'd6;
    #1;
    lo = md_if.md_out;
    md_if.md_op = 4'd0;
    #1;
  endtask

  task automatic check_result(input string name);
    logic [63:0] e;
    logic [31:0] hi, lo;
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no expected entry queued", name);
    end else begin
      e = exp_q.pop_front();
      read_hilo(hi, lo);
      chk({name, " hi"}, 64'(hi), 64'(e[63:32]));
      chk({name, " lo"}, 64'(lo), 64'(e[31:0]));
      m_hi = e[63:32];
      m_lo = e[31:0];
    end
  endtask

  // ---------------- test ----------------
  vec_t vecs[10];

  initial begin
    logic [31:0] hi, lo, ra, rb;
    logic [3:0]  rop;

    vecs[0] = '{4'd1, 32'hFFFFFFFE, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFFA, 5};
    vecs[1] = '{4'd2, 32'hFFFFFFFE, 32'd3, 32'h00000002, 32'hFFFFFFFA, 5};
    vecs[2] = '{4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 10};
    vecs[3] = '{4'd4, 32'hFFFFFFF9, 32'd2, 32'h00000001, 32'h7FFFFFFC, 10};
    vecs[4] = '{4'd1, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h3FFFFFFF, 32'h00000001, 5};
    vecs[5] = '{4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 5};
    vecs[6] = '{4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001, 5};
    vecs[7] = '{4'd3, 32'd7, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 10};
    vecs[8] = '{4'd3, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'h00000003, 10};
    vecs[9] = '{4'd4, 32'd100, 32'd7, 32'h00000002, 32'h0000000E, 10};

    reset = 1'b1;
    md_if.md_op = 4'd0;
    md_if.a = 32'd0;
    md_if.b = 32'd0;
    repeat (3) step();
    reset = 1'b0;

    // Reset state.
    chk("reset busy", 64'(md_if.busy), 64'd0);
    chk("reset stall_req", 64'(md_if.stall_req), 64'd0);
    read_hilo(hi, lo);
    chk("reset hi", 64'(hi), 64'd0);
    chk("reset lo", 64'(lo), 64'd0);

    // Vector table.
    for (int i = 0; i < 10; i++) begin
      issue($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
            {vecs[i].hi, vecs[i].lo}, 1'b1);
      wait_done($sformatf("vec%0d", i), vecs[i].n);
      check_result($sformatf("vec%0d", i));
    end

    // Random operations against the model.
    for (int i = 0; i < 6; i++) begin
      rop = 4'($urandom_range(1, 4));
      ra  = $urandom;
      rb  = $urandom;
      if (rb == 32'd0) rb = 32'd1;
      issue($sformatf("rnd%0d", i), rop, ra, rb, model(rop, ra, rb), 1'b1);
      wait_done($sformatf("rnd%0d", i), (rop <= 4'd2) ? 5 : 10);
      check_result($sformatf("rnd%0d", i));
    end

    // Codes outside the defined set behave as none.
    md_if.md_op = 4'd9;
    #1;
    chk("op9 md_out", 64'(md_if.md_out), 64'd0);
    chk("op9 stall_req", 64'(md_if.stall_req), 64'd0);
    md_if.md_op = 4'd0;

    // mthi / mtlo visible the next cycle.
    md_if.md_op = 4'd7;
    md_if.a = 32'h12345678;
    step();
    md_if.md_op = 4'd5;
    #1;
    chk("mthi readback", 64'(md_if.md_out), 64'h12345678);
    m_hi = 32'h12345678;
    md_if.md_op = 4'd8;
    md_if.a = 32'hCAFEF00D;
    step();
    md_if.md_op = 4'd6;
    #1;
    chk("mtlo readback", 64'(md_if.md_out), 64'hCAFEF00D);
    m_lo = 32'hCAFEF00D;
    md_if.md_op = 4'd0;

    // Divide by zero: full busy period, hi/lo untouched.
    issue("div0", 4'd3, 32'd55, 32'd0, {m_hi, m_lo}, 1'b1);
    wait_done("div0", 10);
    check_result("div0");
    issue("divu0", 4'd4, 32'hFFFFFFFF, 32'd0, {m_hi, m_lo}, 1'b1);
    wait_done("divu0", 10);
    check_result("divu0");

    // Reset in the third busy cycle discards the multiply.
    issue("rst_mult", 4'd1, 32'd5, 32'd7, 64'd0, 1'b0);
    step();
    step();
    chk("rst_mult busy before reset", 64'(md_if.busy), 64'd1);
    reset = 1'b1;
    step();
    chk("rst_mult busy", 64'(md_if.busy), 64'd0);
    chk("rst_mult stall_req", 64'(md_if.stall_req), 64'd0);
    read_hilo(hi, lo);
    chk("rst_mult hi", 64'(hi), 64'd0);
    chk("rst_mult lo", 64'(lo), 64'd0);
    reset = 1'b0;
    step();
    m_hi = 32'd0;
    m_lo = 32'd0;

    // Requests during busy are ignored.
    issue("ign", 4'd1, 32'h00012345, 32'h00000100,
          model(4'd1, 32'h00012345, 32'h00000100), 1'b1);
    step();
    md_if.md_op = 4'd8;
    md_if.a = 32'hDEADBEEF;
    #1;
    chk("ign stall_req", 64'(md_if.stall_req), 64'd1);
    step();
    md_if.md_op = 4'd3;
    md_if.a = 32'd100;
    md_if.b = 32'd3;
    step();
    md_if.md_op = 4'd0;
    wait_done("ign", 2);
    check_result("ign");

    // Special div followed immediately by a multiply with no gap.
    issue("divmin", 4'd3, 32'h80000000, 32'hFFFFFFFF, {32'h0, 32'h80000000}, 1'b1);
    wait_done("divmin", 10);
    issue("b2b", 4'd1, 32'd3, 32'd5, {32'd0, 32'd15}, 1'b1);
    chk("b2b busy", 64'(md_if.busy), 64'd1);
    check_result("divmin");
    wait_done("b2b", 5);
    check_result("b2b");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
# mult_div_unit

Execute-stage multiply/divide unit with architectural HI/LO registers for the five-stage pipeline. It sits beside the ALU in stage E and takes its operands from the same forwarded read1_E/read2_E values. mfhi/mflo results join alu_out_E into the M pipeline register. It models a multi-cycle multiply and divide with a busy counter and raises a stall request that the decode-stage hazard logic uses to hold multiply/divide-class instructions in D.

## Interface
- MULT_CYCLES, default 5: busy duration of mult/multu in cycles. Legal range 1..15.
- DIV_CYCLES, default 10: busy duration of div/divu in cycles. Legal range 1..15.

Ports:
- clk  input  1  pipeline clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- md_op  input  4  operation of the instruction currently in E:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mfhi, 6 mflo, 7 mthi, 8 mtlo.
  - Codes 9–15 are treated as none.
- a  input  32  operand rs (forwarded read1_E).
- b  input  32  operand rt (forwarded read2_E).
- md_out  output  32  HI for mfhi, LO for mflo, 0 otherwise; combinational.
- busy  output  1  registered; high while a multiply/divide is in flight.
- stall_req  output  1  combinational; equals busy OR (md_op in 1..4).

## Operation
- State:
  - hi, lo: 32-bit architectural registers.
  - pend_hi, pend_lo: 32-bit staged result.
  - cnt: 4-bit down-counter.
  - busy flag.
- Reset: hi=lo=pend_hi=pend_lo=0, cnt=0, busy=0. Reset wins over every other event, including an in-flight operation, which is discarded.
- Start: md_op in 1..4 with busy=0 at an edge.
  - Compute the result into pend_hi/pend_lo.
  - Load cnt with MULT_CYCLES or DIV_CYCLES.
  - Set busy=1.
- Results:
  - mult: {pend_hi,pend_lo} = signed 64-bit a*b.
  - multu: {pend_hi,pend_lo} = unsigned 64-bit a*b.
  - div: pend_lo = quotient truncated toward zero, pend_hi = remainder with the sign of the dividend.
  - div special case: 0x80000000 / 0xFFFFFFFF gives lo=0x80000000, hi=0.
  - divu: unsigned quotient in pend_lo, unsigned remainder in pend_hi.
  - Division by zero (div or divu): the operation still runs the full DIV_CYCLES busy period, and hi/lo are left unchanged at completion.
- While busy:
  - cnt decrements by 1 each edge.
  - On the edge where cnt goes 1→0: hi←pend_hi, lo←pend_lo (unless divide-by-zero), and busy←0.
- mthi/mtlo with busy=0: hi←a (mthi) or lo←a (mtlo) at the edge.
- Any md_op ≠ 0 while busy=1 is ignored and leaves state unchanged. Decode stalls on stall_req guarantee this never occurs in a correct pipeline. The bench checks the ignore behaviour anyway.
- mfhi/mflo always return the current architectural hi/lo, never pend_*. Decode stalls prevent them from executing while busy.

## Timing
- A start in cycle T (md_op seen at edge ending T):
  - busy is high for exactly N cycles, T+1..T+N, where N = MULT_CYCLES or DIV_CYCLES.
  - New hi/lo are visible on md_out from cycle T+N+1.
- stall_req:
  - High in cycle T itself, combinationally from md_op.
  - High through T+N via busy.
  - Low at T+N+1 unless a new start is present.
- Back-to-back: a second mult/div may start in cycle T+N+1. Zero dead cycles.
- mthi/mtlo written at the edge ending cycle T are readable by mfhi/mflo in cycle T+1.
- md_out has zero latency: combinational from md_op, hi and lo.

## Test plan
- mult, a=0xFFFFFFFE, b=3 → busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA. multu with the same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div, a=0xFFFFFFF9 (−7), b=2 → busy high 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu with the same operands → lo=0x7FFFFFFC, hi=0x00000001.
- mthi a=0x12345678, next cycle mfhi → md_out=0x12345678. Then div, b=0 → busy 10 cycles; hi still 0x12345678, lo unchanged.
- mult started; reset asserted in the 3rd busy cycle → next cycle busy=0, hi=lo=0, stall_req=0 with md_op=0.
- mult, then md_op=mtlo (a=0xDEADBEEF) applied during busy → ignored; lo after completion equals the product's low word.
- div 0x80000000 / 0xFFFFFFFF → lo=0x80000000, hi=0. A mult issued exactly at cycle T+11 starts with no gap, and stall_req is high in that cycle.
